// File: rtl/pulse_sched_pkg.sv
// pulse_sched_pkg: state encoding, mode codes and fixed-rate divisors for the pulse scheduler
package pulse_sched_pkg;
    typedef enum logic [1:0] {S_IDLE, S_FIXED, S_RUN, S_DONE} state_t;

    localparam logic [1:0] MODE_DIV64  = 2'b00;
    localparam logic [1:0] MODE_DIV128 = 2'b01;
    localparam logic [1:0] MODE_DIV256 = 2'b10;
    localparam logic [1:0] MODE_SCHED  = 2'b11;

    function automatic int unsigned rate_div64(input int unsigned clk_hz);
        return clk_hz / 64;
    endfunction

    function automatic int unsigned rate_div128(input int unsigned clk_hz);
        return clk_hz / 128;
    endfunction

    function automatic int unsigned rate_div256(input int unsigned clk_hz);
        return clk_hz / 256;
    endfunction

    function automatic int unsigned fixed_rate(input int unsigned clk_hz, input logic [1:0] mode);
        return (mode == MODE_DIV128) ? rate_div128(clk_hz) :
               (mode == MODE_DIV256) ? rate_div256(clk_hz) : rate_div64(clk_hz);
    endfunction
endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: one-second timebase; tick is high in the last cycle of each CLK_HZ-cycle window
module sec_tick_gen #(
    parameter int CLK_HZ = 100000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = $clog2(CLK_HZ + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] r_cnt;

    // count 0..CLK_HZ-1 and restart from zero on clear
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_cnt <= '0;
        else r_cnt <= (i_clr || r_cnt == LAST) ? '0 : r_cnt + 1'b1;

    assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/pulse_rate_scheduler.sv
// pulse_rate_scheduler: drives the pulse divider from a fixed rate or a timed segment table and counts returned pulses
module pulse_rate_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int SEG_MAX = 16,
    parameter int DIV_W   = 32,
    parameter int DUR_W   = 8,
    localparam int AW     = $clog2(SEG_MAX),
    localparam int CNT_W  = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic             i_cfg_we,
    input  logic [AW-1:0]    i_cfg_addr,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic [DUR_W-1:0] i_cfg_dur,
    input  logic [CNT_W-1:0] i_seg_count,
    input  logic             i_pulse_in,
    output logic [DIV_W-1:0] o_half_period,
    output logic             o_reload,
    output logic             o_pulse_en,
    output logic [AW-1:0]    o_seg_idx,
    output logic             o_sec_tick,
    output logic             o_busy,
    output logic             o_done,
    output logic [15:0]      o_pulse_count
);
    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_tab_div [SEG_MAX];
    logic [DUR_W-1:0] r_tab_dur [SEG_MAX];
    logic [DIV_W-1:0] r_half_period, w_div;
    logic [DUR_W-1:0] r_remain, w_dur;
    logic [AW-1:0]    r_seg_idx, w_load_idx;
    logic [1:0]       r_mode, r_pin, r_en_d;
    logic             r_reload, r_pulse_en;
    logic [15:0]      r_pulse_count;
    logic [CNT_W-1:0] w_seg_lim;
    logic             w_tick, w_load, w_fix, w_clr, w_last, w_leave_idle, w_edge, w_cnt_en;

    sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_sec (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    assign w_seg_lim    = (i_seg_count > CNT_W'(SEG_MAX)) ? CNT_W'(SEG_MAX) : i_seg_count;
    assign w_last       = (CNT_W'(r_seg_idx) + 1'b1) >= w_seg_lim;
    assign w_leave_idle = (r_state == S_IDLE) && i_start;
    assign w_div        = r_tab_div[w_load_idx];
    assign w_dur        = r_tab_dur[w_load_idx];
    assign w_edge       = r_pin[0] & ~r_pin[1];
    assign w_cnt_en     = r_pulse_en | (|r_en_d);

    // next state plus the load/fixed-reload/timebase-clear strobes; start=0 outranks mode, mode outranks tick
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_fix       = 1'b0;
        w_clr       = 1'b0;
        w_load_idx  = r_seg_idx;
        case (r_state)
            S_IDLE:
                if (i_start) begin
                    w_clr = 1'b1;
                    if (i_mode != MODE_SCHED) begin
                        w_state_nxt = S_FIXED;
                        w_fix       = 1'b1;
                    end else if (i_seg_count == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_load      = 1'b1;
                        w_load_idx  = '0;
                    end
                end
            S_FIXED:
                if (!i_start) w_state_nxt = S_IDLE;
                else if (i_mode == MODE_SCHED) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                    w_load_idx  = '0;
                    w_clr       = 1'b1;
                end else if (i_mode != r_mode) w_fix = 1'b1;
            S_RUN:
                if (!i_start) w_state_nxt = S_IDLE;
                else if (i_mode != MODE_SCHED) begin
                    w_state_nxt = S_FIXED;
                    w_fix       = 1'b1;
                end else if (w_tick && r_remain <= DUR_W'(1)) begin
                    if (w_last) w_state_nxt = S_DONE;
                    else begin
                        w_load     = 1'b1;
                        w_load_idx = r_seg_idx + 1'b1;
                        w_clr      = 1'b1;
                    end
                end
            S_DONE:
                if (!i_start) w_state_nxt = S_IDLE;
        endcase
    end

    // registered divider controls; a rest segment (div 0) keeps the old half-period with the output gated off
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_half_period <= '0;
            r_reload      <= 1'b0;
            r_pulse_en    <= 1'b0;
            r_seg_idx     <= '0;
            r_remain      <= '0;
            r_mode        <= MODE_DIV64;
        end else begin
            r_state       <= w_state_nxt;
            r_reload      <= w_load | w_fix;
            r_half_period <= w_fix ? DIV_W'(fixed_rate(CLK_HZ, i_mode)) :
                             (w_load && w_div != '0) ? w_div : r_half_period;
            r_pulse_en    <= w_fix ? 1'b1 : w_load ? (w_div != '0) :
                             ((w_state_nxt == S_FIXED || w_state_nxt == S_RUN) && r_pulse_en);
            r_seg_idx     <= w_load ? w_load_idx : r_seg_idx;
            r_remain      <= w_load ? ((w_dur == '0) ? DUR_W'(1) : w_dur) :
                             (r_state == S_RUN && w_tick && r_remain != '0) ? r_remain - 1'b1 : r_remain;
            r_mode        <= w_fix ? i_mode : r_mode;
        end

    // segment table; writes to addresses past the table are dropped
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            for (int i = 0; i < SEG_MAX; i++) begin
                r_tab_div[i] <= '0;
                r_tab_dur[i] <= '0;
            end
        end else if (i_cfg_we && int'(i_cfg_addr) < SEG_MAX) begin
            r_tab_div[i_cfg_addr] <= i_cfg_div;
            r_tab_dur[i_cfg_addr] <= i_cfg_dur;
        end

    // two-flop edge detector on the returned pulse and a short trailing window of the enable
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_pin  <= '0;
            r_en_d <= '0;
        end else begin
            r_pin  <= {r_pin[0], i_pulse_in};
            r_en_d <= {r_en_d[0], r_pulse_en};
        end

    // saturating pulse counter, restarted whenever a run begins
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_pulse_count <= '0;
        else r_pulse_count <= w_leave_idle ? '0 :
                              (w_edge && w_cnt_en && r_pulse_count != 16'hFFFF) ? r_pulse_count + 1'b1 : r_pulse_count;

    assign o_half_period = r_half_period;
    assign o_reload      = r_reload;
    assign o_pulse_en    = r_pulse_en;
    assign o_seg_idx     = r_seg_idx;
    assign o_sec_tick    = w_tick;
    assign o_busy        = (r_state == S_FIXED) || (r_state == S_RUN);
    assign o_done        = (r_state == S_DONE);
    assign o_pulse_count = r_pulse_count;
endmodule

// File: tb/tb_pulse_rate_scheduler.sv
// tb_pulse_rate_scheduler: directed scenarios with a scoreboard of expected reload/done events and output snapshots
module tb_pulse_rate_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [31:0] cfg_div = '0;
    logic [7:0]  cfg_dur = '0;
    logic [4:0]  seg_count = '0;
    logic        pulse_in = 1'b0;
    logic [31:0] half_period;
    logic        reload, pulse_en, sec_tick, busy, done;
    logic [3:0]  seg_idx;
    logic [15:0] pulse_count;

    pulse_rate_scheduler #(.CLK_HZ(1024), .SEG_MAX(12), .DIV_W(32), .DUR_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
        .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_div(cfg_div), .i_cfg_dur(cfg_dur),
        .i_seg_count(seg_count), .i_pulse_in(pulse_in),
        .o_half_period(half_period), .o_reload(reload), .o_pulse_en(pulse_en), .o_seg_idx(seg_idx),
        .o_sec_tick(sec_tick), .o_busy(busy), .o_done(done), .o_pulse_count(pulse_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          tag;
        logic [31:0] hp;
        logic        rl, en, bz, dn, st;
        logic [3:0]  idx;
        logic [15:0] pc;
    } snap_t;

    typedef struct {
        logic [31:0] hp;
        logic        en, dn;
        logic [3:0]  idx;
        int          cyc;
    } ev_t;

    snap_t snap_q[$];
    ev_t   ev_q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    tag_n = 0;
    int    ev_n = 0;
    logic  prev_done = 1'b0;
    snap_t ms;
    ev_t   me;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: compares queued snapshots every cycle and each reload or done-entry against the event queue
    always @(negedge clk) begin
        while (snap_q.size() != 0) begin
            ms = snap_q.pop_front();
            if (ms.kind == 2) chk($sformatf("s%0d_pending_events", ms.tag), 64'(ev_q.size()), 64'd0);
            else if (ms.kind == 1) chk($sformatf("s%0d_sec_tick", ms.tag), 64'(sec_tick), 64'(ms.st));
            else begin
                chk($sformatf("s%0d_half_period", ms.tag), 64'(half_period), 64'(ms.hp));
                chk($sformatf("s%0d_reload", ms.tag), 64'(reload), 64'(ms.rl));
                chk($sformatf("s%0d_pulse_en", ms.tag), 64'(pulse_en), 64'(ms.en));
                chk($sformatf("s%0d_seg_idx", ms.tag), 64'(seg_idx), 64'(ms.idx));
                chk($sformatf("s%0d_busy", ms.tag), 64'(busy), 64'(ms.bz));
                chk($sformatf("s%0d_done", ms.tag), 64'(done), 64'(ms.dn));
                chk($sformatf("s%0d_pulse_count", ms.tag), 64'(pulse_count), 64'(ms.pc));
            end
        end
        if (reload || (done && !prev_done)) begin
            if (ev_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: reload=%0b done=%0b hp=%0d at cycle %0d, none expected", reload, done, half_period, cyc);
            end else begin
                me = ev_q.pop_front();
                chk($sformatf("ev%0d_cycle", ev_n), 64'(cyc), 64'(me.cyc));
                chk($sformatf("ev%0d_half_period", ev_n), 64'(half_period), 64'(me.hp));
                chk($sformatf("ev%0d_pulse_en", ev_n), 64'(pulse_en), 64'(me.en));
                chk($sformatf("ev%0d_seg_idx", ev_n), 64'(seg_idx), 64'(me.idx));
                chk($sformatf("ev%0d_done", ev_n), 64'(done), 64'(me.dn));
                ev_n++;
            end
        end
        prev_done = done;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic snap(input logic [31:0] hp, input logic rl, input logic en, input logic [3:0] idx,
                        input logic bz, input logic dn, input logic [15:0] pc);
        snap_t it;
        it.kind = 0; it.tag = tag_n; it.hp = hp; it.rl = rl; it.en = en; it.idx = idx;
        it.bz = bz; it.dn = dn; it.pc = pc; it.st = 1'b0;
        tag_n++;
        snap_q.push_back(it);
    endtask

    task automatic snap_kind(input int kind, input logic st);
        snap_t it;
        it.kind = kind; it.tag = tag_n; it.st = st; it.hp = '0; it.rl = 1'b0; it.en = 1'b0;
        it.idx = '0; it.bz = 1'b0; it.dn = 1'b0; it.pc = '0;
        tag_n++;
        snap_q.push_back(it);
    endtask

    task automatic expect_ev(input logic [31:0] hp, input logic en, input logic [3:0] idx, input logic dn, input int at);
        ev_t it;
        it.hp = hp; it.en = en; it.idx = idx; it.dn = dn; it.cyc = at;
        ev_q.push_back(it);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] dv, input logic [7:0] du);
        cfg_we = 1'b1; cfg_addr = a; cfg_div = dv; cfg_dur = du;
        step(1);
        cfg_we = 1'b0;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            pulse_in = 1'b1;
            step(1);
            pulse_in = 1'b0;
            step(1);
        end
    endtask

    initial begin
        int c, c2, c3;
        #2 rst_n = 1'b0;
        step(3);
        snap(0, 0, 0, 0, 0, 0, 0);
        snap_kind(1, 1'b0);
        rst_n = 1'b1;
        step(1);

        // reset while running, then fixed mode 00
        wr(0, 10, 2);
        wr(1, 20, 1);
        mode = 2'b11; seg_count = 2; start = 1'b1; c = cyc;
        expect_ev(10, 1, 0, 0, c + 1);
        step(5);
        rst_n = 1'b0;
        snap(0, 0, 0, 0, 0, 0, 0);
        step(2);
        start = 1'b0; mode = 2'b00; rst_n = 1'b1;
        step(1);
        start = 1'b1; c = cyc;
        expect_ev(16, 1, 0, 0, c + 1);
        step(1);
        snap(16, 1, 1, 0, 1, 0, 0);

        // fixed-mode change 00 -> 10, then stop
        mode = 2'b10; c = cyc;
        expect_ev(4, 1, 0, 0, c + 1);
        step(1);
        snap(4, 1, 1, 0, 1, 0, 0);
        step(1);
        snap(4, 0, 1, 0, 1, 0, 0);
        start = 1'b0;
        step(1);
        snap(4, 0, 0, 0, 0, 0, 0);

        // two-segment schedule with second-tick timing
        wr(0, 10, 2);
        wr(1, 20, 1);
        mode = 2'b11; seg_count = 2; start = 1'b1; c = cyc;
        expect_ev(10, 1, 0, 0, c + 1);
        expect_ev(20, 1, 1, 0, c + 2049);
        expect_ev(20, 0, 1, 1, c + 3073);
        step_to(c + 1023);
        snap_kind(1, 1'b0);
        step(1);
        snap_kind(1, 1'b1);
        step(1);
        snap_kind(1, 1'b0);
        step_to(c + 1500);
        snap(10, 0, 1, 0, 1, 0, 0);
        step_to(c + 3075);
        snap(20, 0, 0, 1, 0, 1, 0);
        start = 1'b0;
        step(1);
        snap(20, 0, 0, 1, 0, 0, 0);

        // rest segment between two div-6 segments, with pulse counting
        wr(0, 6, 1);
        wr(1, 0, 1);
        wr(2, 6, 1);
        seg_count = 3; start = 1'b1; c = cyc;
        expect_ev(6, 1, 0, 0, c + 1);
        expect_ev(6, 0, 1, 0, c + 1025);
        expect_ev(6, 1, 2, 0, c + 2049);
        expect_ev(6, 0, 2, 1, c + 3073);
        step_to(c + 100);
        pulses(10);
        step(5);
        snap(6, 0, 1, 0, 1, 0, 10);
        step_to(c + 1300);
        pulses(7);
        step(5);
        snap(6, 0, 0, 1, 1, 0, 10);
        step_to(c + 2300);
        pulses(5);
        step(5);
        snap(6, 0, 1, 2, 1, 0, 15);
        step_to(c + 3080);
        snap(6, 0, 0, 2, 0, 1, 15);
        start = 1'b0;
        step(1);

        // 11 -> 01 in RUN, back to 11 from FIXED, then abort mid-segment
        wr(0, 10, 2);
        seg_count = 1; mode = 2'b11; start = 1'b1; c = cyc;
        expect_ev(10, 1, 0, 0, c + 1);
        step_to(c + 50);
        mode = 2'b01; c2 = cyc;
        expect_ev(8, 1, 0, 0, c2 + 1);
        step(1);
        snap(8, 1, 1, 0, 1, 0, 0);
        step_to(c2 + 20);
        mode = 2'b11; c3 = cyc;
        expect_ev(10, 1, 0, 0, c3 + 1);
        step(1);
        snap(10, 1, 1, 0, 1, 0, 0);
        step_to(c3 + 100);
        start = 1'b0;
        step(1);
        snap(10, 0, 0, 0, 0, 0, 0);

        // seg_count = 0 goes straight to DONE
        seg_count = 0; start = 1'b1; c = cyc;
        expect_ev(10, 0, 0, 1, c + 1);
        step(1);
        snap(10, 0, 0, 0, 0, 1, 0);
        start = 1'b0;
        step(1);

        // dur = 0 lasts one second; out-of-range write is dropped
        wr(0, 12, 0);
        wr(12, 99, 3);
        seg_count = 1; start = 1'b1; c = cyc;
        expect_ev(12, 1, 0, 0, c + 1);
        expect_ev(12, 0, 0, 1, c + 1025);
        step_to(c + 1027);
        start = 1'b0;
        step(1);

        // seg_count above the table size is clamped
        for (int k = 0; k < 12; k++) wr(4'(k), 32'(k + 2), 8'd1);
        seg_count = 20; start = 1'b1; c = cyc;
        for (int k = 0; k < 12; k++) expect_ev(32'(k + 2), 1, 4'(k), 0, c + 1 + 1024 * k);
        expect_ev(13, 0, 11, 1, c + 1 + 12 * 1024);
        step_to(c + 12295);
        snap(13, 0, 0, 11, 0, 1, 0);
        start = 1'b0;
        step(1);

        // pulse counter saturation
        mode = 2'b00; start = 1'b1; c = cyc;
        expect_ev(16, 1, 11, 0, c + 1);
        step(1);
        force dut.r_pulse_count = 16'hFFF0;
        step(1);
        release dut.r_pulse_count;
        step(1);
        pulses(20);
        step(5);
        snap(16, 0, 1, 11, 1, 0, 16'hFFFF);
        start = 1'b0;
        step(1);
        snap(16, 0, 0, 11, 0, 0, 16'hFFFF);

        step(3);
        snap_kind(2, 1'b0);
        step(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pulse_rate_scheduler.md
# pulse_rate_scheduler

Controller that sequences the variable-rate pulse divider. It selects a fixed rate from `mode` or steps through a programmable table of rate/duration segments, one second per duration unit. It drives the divider's half-period value with a reload strobe and counts the pulses the divider returns. It sits between the user inputs (start, mode, configuration writes) and the pulse generator datapath.

## Interface
- `CLK_HZ`, default 100000000: system clock frequency; one second is this many cycles.
- `SEG_MAX`, default 16: number of table segments.
- `DIV_W`, default 32: half-period width.
- `DUR_W`, default 8: segment duration width, in seconds.
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: level; high = run, low = stop/abort.
- `mode`  in  2: 00/01/10 fixed rate, 11 scheduled.
- `cfg_we`  in  1: table write strobe.
- `cfg_addr`  in  $clog2(SEG_MAX): segment index.
- `cfg_div`  in  DIV_W: segment half-period, in clk cycles.
- `cfg_dur`  in  DUR_W: segment duration, in seconds.
- `seg_count`  in  $clog2(SEG_MAX)+1: number of active segments.
- `pulse_in`  in  1: divider output, fed back for counting.
- `half_period`  out  DIV_W: divider terminal count.
- `reload`  out  1: one-cycle strobe that restarts the divider.
- `pulse_en`  out  1: divider output enable.
- `seg_idx`  out  $clog2(SEG_MAX): current segment.
- `sec_tick`  out  1: one-cycle pulse every CLK_HZ cycles.
- `busy`  out  1: state is FIXED or RUN.
- `done`  out  1: schedule complete.
- `pulse_count`  out  16: rising edges of `pulse_in` while `pulse_en` is high; saturates at 0xFFFF.

## Operation
- Fixed rates (in package): mode 00 uses CLK_HZ/64, 01 uses CLK_HZ/128, 10 uses CLK_HZ/256. At 100 MHz these are 1562500, 781250 and 390625.
- Table: SEG_MAX entries of {div, dur}; all entries reset to 0.
  - A write with `cfg_addr` ≥ SEG_MAX is ignored.
  - A write is allowed at any time. It takes effect when that segment is next loaded; a segment's values are latched at load.
- Segment rules:
  - dur=0 is treated as 1 second.
  - div=0 marks a rest segment: `pulse_en`=0 for its duration, and `half_period` holds its previous value.
- States: IDLE, FIXED, RUN, DONE.
- IDLE: `pulse_en`=0, `busy`=0. When `start`=1:
  - mode≠11 → FIXED.
  - mode=11 and seg_count=0 → DONE.
  - otherwise load segment 0 → RUN.
  - On leaving IDLE: clear `pulse_count`, and clear the second counter.
- FIXED: `half_period` follows the `mode` constant and `pulse_en`=1.
  - A change in `mode` between fixed values reloads the new constant.
  - `mode`→11 loads segment 0 → RUN, with the second counter cleared.
  - `start`=0 → IDLE.
- RUN: on each `sec_tick`, decrement the remaining duration. At zero, advance `seg_idx`:
  - if `seg_idx`+1 = seg_count → DONE;
  - otherwise load the next segment.
  - `mode` leaving 11 → FIXED, with reload. `start`=0 → IDLE.
  - Priority: `start`=0 beats a `mode` change, which beats a tick.
- DONE: `pulse_en`=0, `done`=1. `start`=0 → IDLE, which clears `done`.
- `seg_count` > SEG_MAX is clamped to SEG_MAX. It is sampled at segment advance only.
- Reset mid-operation: go to IDLE immediately and apply all output reset values.

## Timing
- Reset values: `half_period`=0, `reload`=0, `pulse_en`=0, `seg_idx`=0, `sec_tick`=0, `busy`=0, `done`=0, `pulse_count`=0, state IDLE.
- `start` is sampled on `clk`. The new `half_period`, `reload`=1 and `pulse_en` are registered outputs, valid in the cycle after the first sampled high (latency 1).
- Every load or mode change asserts `reload` for exactly one cycle, together with the new `half_period`.
- `sec_tick` fires on cycle CLK_HZ after a counter clear. A segment of duration d therefore lasts exactly d·CLK_HZ cycles from its load.
- Advance: the segment load or the DONE entry is registered in the cycle after the `sec_tick` that exhausts the duration.
- `pulse_in` is registered through a 2-flop edge detector. Counts lag by 2 cycles.
- Edges arriving after `pulse_en` falls are counted for 2 more cycles only.

## Structure
- `pulse_sched_pkg` contains:
  - the state enum;
  - the mode encodings;
  - the three fixed-rate constants, as functions of CLK_HZ.
- Sub-module `sec_tick_gen`: counter with a synchronous clear, emitting one-cycle `sec_tick` every CLK_HZ cycles.
- Table: register array, asynchronous read at load.

## Test plan
Simulation uses CLK_HZ=1024 (fixed rates 16/8/4).
- Reset while in RUN: every output returns to its reset value immediately; after release, `start`=1 with mode 00 → `half_period`=16, `reload`=1 one cycle later.
- Schedule {div 10, dur 2}, {div 20, dur 1}, seg_count=2, mode 11, start=1:
  - `half_period`=10 for 2048 cycles, then 20 for 1024 cycles;
  - then `done`=1, `pulse_en`=0, `seg_idx`=1.
- Rest segment: {div 0, dur 1} between two div-6 segments → `pulse_en` low for exactly 1024 cycles; `pulse_count` is unchanged during the rest segment.
- Mode change while running:
  - 00→10 in FIXED → `half_period` 16→4, with a one-cycle `reload`;
  - 11→01 in RUN → FIXED with `half_period`=8.
- Abort and boundaries:
  - `start`=0 mid-segment → IDLE next cycle;
  - seg_count=0 → immediate DONE;
  - a dur=0 segment lasts 1024 cycles;
  - a write with `cfg_addr`=SEG_MAX is ignored.
- Count saturation: force 70000 `pulse_in` edges → `pulse_count`=0xFFFF.
